// File: rtl/lfsr_bist_controller_pkg.sv
// Shared types and constants for the LFSR memory BIST.
// State encoding, phase values and default seed.
package lfsr_bist_controller_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_RLOAD = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    WRITE = ST_WRITE,
    RLOAD = ST_RLOAD,
    READ  = ST_READ,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  localparam logic PH_TRUE = 1'b0;
  localparam logic PH_INV  = 1'b1;

  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_CAFE;

  function automatic logic can_start(input state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/lfsr_bist_controller_fail_tracker.sv
// Read-back compare for the BIST: delayed read tracking,
// saturating mismatch counter and first-fail address capture.
module bist_fail_tracker #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int FAIL_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0]     expected,
  input  logic [DATA_WIDTH-1:0]     rdata,
  output logic                      cmp_valid,
  output logic [FAIL_CNT_WIDTH-1:0] fail_count,
  output logic [ADDR_WIDTH-1:0]     fail_addr
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  seen_q;
  logic                  miss;

  assign miss = cmp_valid && (rdata != expected);

  // Track each read one cycle and fold mismatches into the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_valid  <= 1'b0;
      addr_q     <= '0;
      seen_q     <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
    end else begin
      cmp_valid <= rd_en;
      addr_q    <= rd_addr;
      if (clear) begin
        seen_q     <= 1'b0;
        fail_count <= '0;
        fail_addr  <= '0;
      end else if (miss) begin
        if (fail_count != '1)
          fail_count <= fail_count + FAIL_CNT_WIDTH'(1);
        if (!seen_q) begin
          seen_q    <= 1'b1;
          fail_addr <= addr_q;
        end
      end
    end
  end

endmodule

// File: rtl/lfsr_bist_controller.sv
// Random-pattern memory BIST sequencer: fill with LFSR data,
// reload seed, read back and compare; true then inverted pass.
module lfsr_bist_controller
  import lfsr_bist_controller_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int FAIL_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     seed_value,
  output logic                      lfsr_load_seed,
  output logic [DATA_WIDTH-1:0]     lfsr_seed,
  output logic                      lfsr_enable,
  input  logic [DATA_WIDTH-1:0]     lfsr_pattern,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic                      mem_we,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      mem_re,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [FAIL_CNT_WIDTH-1:0] fail_count,
  output logic [ADDR_WIDTH-1:0]     fail_addr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  ph;
  logic                  accept;
  logic                  last;
  logic                  cmp_valid;
  logic [DATA_WIDTH-1:0] pat;

  assign accept = start && can_start(state);
  assign last   = (cnt == ADDR_WIDTH'(DEPTH - 1));
  assign pat    = lfsr_pattern ^ {DATA_WIDTH{ph}};

  assign lfsr_load_seed = (state == LOAD) || (state == RLOAD);
  assign mem_we         = (state == WRITE);
  assign mem_re         = (state == READ);
  assign lfsr_enable    = mem_we || cmp_valid;
  assign mem_addr       = (mem_we || mem_re) ? cnt : '0;
  assign mem_wdata      = mem_we ? pat : '0;
  assign pass           = done && (fail_count == '0);

  // Sequencer: state, address counter, phase and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ph        <= PH_TRUE;
      lfsr_seed <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            lfsr_seed <= seed_value;
            ph        <= PH_TRUE;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= WRITE;
        end
        WRITE: begin
          if (last) begin
            cnt   <= '0;
            state <= RLOAD;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        RLOAD: begin
          cnt   <= '0;
          state <= READ;
        end
        READ: begin
          if (last) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (ph == PH_TRUE) begin
            ph    <= PH_INV;
            state <= LOAD;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bist_fail_tracker #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .FAIL_CNT_WIDTH(FAIL_CNT_WIDTH)
  ) u_track (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .rd_en     (mem_re),
    .rd_addr   (mem_addr),
    .expected  (pat),
    .rdata     (mem_rdata),
    .cmp_valid (cmp_valid),
    .fail_count(fail_count),
    .fail_addr (fail_addr)
  );

endmodule

// File: tb/tb_lfsr_bist_controller.sv
// Bench for lfsr_bist_controller: LFSR and memory models,
// table of fault scenarios plus reset/start/saturation cases.
module tb_lfsr_bist_controller;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int FW = 16;
  localparam int D  = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] seed_value;
  logic          lfsr_load_seed;
  logic [DW-1:0] lfsr_seed;
  logic          lfsr_enable;
  logic [DW-1:0] lfsr_pattern;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic          pass;
  logic [FW-1:0] fail_count;
  logic [AW-1:0] fail_addr;

  logic          start2;
  logic          load2;
  logic [DW-1:0] seed2;
  logic          en2;
  logic [DW-1:0] pat2;
  logic [AW-1:0] addr2;
  logic          we2;
  logic [DW-1:0] wdata2;
  logic          re2;
  logic          busy2;
  logic          done2;
  logic          pass2;
  logic [1:0]    fcnt2;
  logic [AW-1:0] faddr2;

  always #5 clk = ~clk;

  lfsr_bist_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FAIL_CNT_WIDTH(FW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed_value(seed_value),
    .lfsr_load_seed(lfsr_load_seed), .lfsr_seed(lfsr_seed),
    .lfsr_enable(lfsr_enable), .lfsr_pattern(lfsr_pattern),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy),
    .done(done), .pass(pass), .fail_count(fail_count),
    .fail_addr(fail_addr)
  );

  lfsr_bist_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FAIL_CNT_WIDTH(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .seed_value(32'h1357_9BDF),
    .lfsr_load_seed(load2), .lfsr_seed(seed2),
    .lfsr_enable(en2), .lfsr_pattern(pat2),
    .mem_addr(addr2), .mem_we(we2), .mem_wdata(wdata2),
    .mem_re(re2), .mem_rdata(32'h0), .busy(busy2),
    .done(done2), .pass(pass2), .fail_count(fcnt2),
    .fail_addr(faddr2)
  );

  function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // External LFSR generators.
  always @(posedge clk) begin
    if (rst) lfsr_pattern <= '0;
    else if (lfsr_load_seed) lfsr_pattern <= lfsr_seed;
    else if (lfsr_enable) lfsr_pattern <= lfsr_next(lfsr_pattern);
    if (rst) pat2 <= '0;
    else if (load2) pat2 <= seed2;
    else if (en2) pat2 <= lfsr_next(pat2);
  end

  logic [DW-1:0] mem   [D];
  logic [DW-1:0] stuck [D];

  // Memory under test with stuck-at-1 bit masks on read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr] | stuck[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] seed;
    int            cycles;
    logic          pass;
    int            fcnt;
    int            faddr;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [DW-1:0] seed;
    int            a0;
    logic [DW-1:0] m0;
    int            a1;
    logic [DW-1:0] m1;
    int            faddr;
  } vec_t;

  function automatic void model(input logic [DW-1:0] s,
                                output int cnt, output int fa);
    logic [DW-1:0] p;
    logic [DW-1:0] w;
    cnt = 0;
    fa  = 0;
    for (int ph = 0; ph < 2; ph++) begin
      p = s;
      for (int a = 0; a < D; a++) begin
        w = (ph == 1) ? ~p : p;
        if ((w | stuck[a]) != w) begin
          if (cnt == 0) fa = a;
          cnt++;
        end
        p = lfsr_next(p);
      end
    end
  endfunction

  task automatic push_exp(input logic [DW-1:0] s);
    exp_t e;
    int   c;
    int   fa;
    model(s, c, fa);
    e.seed   = s;
    e.cycles = 4 * D + 7;
    e.pass   = (c == 0);
    e.fcnt   = c;
    e.faddr  = fa;
    sb.push_back(e);
  endtask

  // Start a run, optionally poke start while busy, then score it.
  task automatic run(input logic [DW-1:0] s, input int poke_at,
                     input logic [DW-1:0] poke_seed);
    int   cyc;
    int   we_n;
    int   re_n;
    int   bad;
    exp_t e;
    we_n = 0;
    re_n = 0;
    bad  = 0;
    @(negedge clk);
    seed_value = s;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    chk("busy_c1", busy, 1);
    chk("done_c1", done, 0);
    while (!done && cyc < 400) begin
      we_n += int'(mem_we);
      re_n += int'(mem_re);
      if (mem_we && mem_re) bad++;
      if (lfsr_load_seed && lfsr_enable) bad++;
      if (cyc == poke_at) begin
        start      = 1'b1;
        seed_value = poke_seed;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("done_cycle", cyc, e.cycles);
      chk("done", done, 1);
      chk("busy_done", busy, 0);
      chk("pass", pass, e.pass);
      chk("fail_count", fail_count, e.fcnt);
      chk("fail_addr", fail_addr, e.faddr);
      chk("seed", lfsr_seed, e.seed);
      chk("we_pulses", we_n, 2 * D);
      chk("re_pulses", re_n, 2 * D);
      chk("exclusive", bad, 0);
    end
  endtask

  vec_t vt[3];

  initial begin
    int cyc;
    rst        = 1'b1;
    start      = 1'b0;
    start2     = 1'b0;
    seed_value = '0;
    for (int a = 0; a < D; a++) stuck[a] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fcnt", fail_count, 0);
    chk("rst_faddr", fail_addr, 0);
    chk("rst_seed", lfsr_seed, 0);
    rst = 1'b0;

    vt[0] = '{32'hACE1_CAFE, 0, 32'h0, 0, 32'h0, 0};
    vt[1] = '{32'hACE1_CAFE, 9, 32'h20, 0, 32'h0, 9};
    vt[2] = '{32'h1234_5678, 3, 32'h20, 12, 32'h81, 3};

    foreach (vt[i]) begin
      for (int a = 0; a < D; a++) stuck[a] = '0;
      stuck[vt[i].a0] |= vt[i].m0;
      stuck[vt[i].a1] |= vt[i].m1;
      push_exp(vt[i].seed);
      chk("tbl_faddr", sb[sb.size() - 1].faddr, vt[i].faddr);
      run(vt[i].seed, -1, '0);
    end

    // Reset in the middle of READ of pass 0.
    for (int a = 0; a < D; a++) stuck[a] = '0;
    @(negedge clk);
    seed_value = 32'hACE1_CAFE;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_read", mem_re, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_seed", lfsr_seed, 0);
    chk("abort_strobes", {mem_we, mem_re, lfsr_load_seed, lfsr_enable}, 0);
    chk("abort_cnt", {fail_count, fail_addr, pass}, 0);
    rst = 1'b0;
    push_exp(32'hACE1_CAFE);
    run(32'hACE1_CAFE, -1, '0);

    // start while busy is ignored; start in DONE reruns with new seed.
    push_exp(32'h0BAD_F00D);
    run(32'h0BAD_F00D, 10, 32'h5555_AAAA);
    stuck[7] = 32'h4;
    push_exp(32'h7777_1111);
    run(32'h7777_1111, -1, '0);

    // Saturating 2-bit counter against an all-zero memory.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc    = 1;
    while (!done2 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("sat_cycle", cyc, 4 * D + 7);
    chk("sat_fcnt", fcnt2, 3);
    chk("sat_pass", pass2, 0);
    chk("sat_faddr", faddr2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_bist_controller.md
Name: lfsr_bist_controller

Overview:
Sequencer for random-pattern memory BIST. It drives the LFSR pattern generator (seed load, step enable) and a single-port synchronous memory under test. Each pass fills the memory with an LFSR sequence, reloads the same seed, then reads the memory back and compares each word against the regenerated sequence. It runs two passes, true data then inverted data, and reports pass/fail, the failure count and the first failing address. It sits between the BIST top-level start/status interface, the LFSR generator and the memory wrapper.

Parameters:
ADDR_WIDTH, 8, memory address width; test depth DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 32, memory and pattern word width
FAIL_CNT_WIDTH, 16, width of the saturating failure counter

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  pulse or level; sampled only in IDLE or DONE
seed_value  input  DATA_WIDTH  seed used for both passes, captured when start is accepted
lfsr_load_seed  output  1  load lfsr_seed into the LFSR this cycle
lfsr_seed  output  DATA_WIDTH  captured seed
lfsr_enable  output  1  advance the LFSR one step this cycle
lfsr_pattern  input  DATA_WIDTH  current LFSR value
mem_addr  output  ADDR_WIDTH  memory address
mem_we  output  1  write strobe
mem_wdata  output  DATA_WIDTH  write data
mem_re  output  1  read strobe
mem_rdata  input  DATA_WIDTH  read data, valid the cycle after mem_re
busy  output  1  test in progress
done  output  1  test complete; held high in DONE
pass  output  1  valid while done=1; 1 means zero mismatches
fail_count  output  FAIL_CNT_WIDTH  mismatches over both passes, saturating
fail_addr  output  ADDR_WIDTH  address of the first mismatch

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While rst=1, state goes to IDLE and all outputs and registers are cleared to 0, including lfsr_seed, pass, fail_count and fail_addr. Reset mid-test aborts immediately with no partial done.
- States: IDLE, LOAD, WRITE, RLOAD, READ, DRAIN, DONE. Pass bit ph: 0 means true data, 1 means inverted data.
- IDLE, or DONE with start=1: capture seed_value, clear fail_count, fail_addr and first-fail flag, set ph=0, go to LOAD. busy=1 from the next cycle. done drops on leaving DONE.
- LOAD: lfsr_load_seed=1, addr counter cleared to 0, next state WRITE.
- WRITE: each cycle mem_we=1, mem_addr=cnt, mem_wdata = lfsr_pattern, or ~lfsr_pattern when ph=1. lfsr_enable=1. cnt increments. When cnt=DEPTH-1, go to RLOAD.
- RLOAD: lfsr_load_seed=1, cnt cleared to 0, next state READ.
- READ: each cycle mem_re=1, mem_addr=cnt, cnt increments. A one-cycle delayed valid and address pipeline tracks each read. When cnt=DEPTH-1, go to DRAIN.
- Compare: in every cycle where the delayed valid is set, expected = lfsr_pattern (inverted when ph=1) is compared with mem_rdata. lfsr_enable=1 in exactly those cycles. On mismatch, fail_count increments, saturating at all-ones. On the first mismatch only, fail_addr takes the delayed address.
- DRAIN: the final compare happens here. If ph=0, set ph=1 and go to LOAD. If ph=1, go to DONE.
- DONE: busy=0, done=1, pass=(fail_count==0). Outputs hold until start or rst.
- start while busy is ignored.
- lfsr_load_seed and lfsr_enable are never high in the same cycle.
- Timing: per pass, 2*DEPTH+3 cycles. With the start sample cycle as cycle 0, done first goes high at cycle 4*DEPTH+7.
- mem_we and mem_re are mutually exclusive. Both are 0 outside WRITE and READ.

Decomposition:
- Shared package: state encoding localparams (IDLE..DONE), phase constants PH_TRUE=0 and PH_INV=1, default seed 32'hACE1_CAFE.
- One natural sub-module, bist_fail_tracker: holds the delayed valid/address pipeline, comparator, saturating fail counter and first-fail capture.
- The LFSR generator stays an external instance wired by the BIST top.

Test Plan:
- ADDR_WIDTH=4, fault-free memory, seed 32'hACE1_CAFE, start pulse at cycle 0 -> done=1 at cycle 71, pass=1, fail_count=0, exactly 32 mem_we pulses and 32 mem_re pulses.
- Memory model with bit 5 of address 9 stuck at 1 -> fail_addr=9. fail_count is 1 or 2 depending on pattern bit 5 in each phase; the bench computes the exact value from the LFSR reference model. pass=0.
- Stuck-at on addresses 3 and 12 -> fail_addr=3 (first only), fail_count equals the model count.
- Assert rst at cycle 20, in the middle of READ of pass 0 -> next cycle all outputs 0, state IDLE. A fresh start then completes with pass=1.
- Pulse start at cycle 10 while busy -> no effect, done still at cycle 71. start in DONE -> done drops next cycle and the test reruns with the new seed_value.
- FAIL_CNT_WIDTH=2, memory returning all-zeros -> fail_count saturates at 3, pass=0.
